// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - sequential instruction prefetch FIFO between CPU fetch port and req/ack memory
//
// Purpose:
//   Prefetches sequential instruction words into a DEPTH-entry FIFO of
//   {addr, inst} pairs. The CPU is served from the FIFO head. A stall is
//   requested while the wanted PC is not yet buffered. Any non-sequential PC
//   flushes the FIFO and restarts fetching at that PC.
//
// Optional build macro:
//   PREFETCH_STATS_EN - adds saturating hit/redirect counters hit_cnt_o and
//   redirect_cnt_o.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   cpu_ce_i       fetch enable from the PC stage
//   cpu_addr_i     fetch address (word aligned)
//   cpu_inst_o     instruction for cpu_addr_i, combinational from FIFO head
//   cpu_valid_o    cpu_inst_o is valid this cycle
//   stallreq_o     pipeline stall request
//   mem_req_o      memory read request, held until acknowledged
//   mem_addr_o     memory read address, held until acknowledged
//   mem_rdata_i    memory read data, valid with mem_ack_i
//   mem_ack_i      one-cycle acknowledge
//   hit_cnt_o      (PREFETCH_STATS_EN) saturating hit counter
//   redirect_cnt_o (PREFETCH_STATS_EN) saturating redirect counter

module inst_prefetch_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_valid_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       redirect_cnt_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              pending;

  logic ce, empty, head_match, hit, redirect, space, accept, push;

  // Combinational outputs are forced quiet while reset is asserted.
  assign ce         = cpu_ce_i & rst;
  assign empty      = (count == '0);
  // Only stored entries can match: an entry pushed this cycle is served next cycle.
  assign head_match = !empty && (fifo_addr[rd_ptr] == cpu_addr_i);
  assign hit        = ce && head_match;
  assign redirect   = ce && (state != IDLE) && !head_match &&
                      !(empty && (fetch_addr == cpu_addr_i));
  // A pop in the same cycle frees a slot for a new request.
  assign space      = (count < CNT_W'(DEPTH)) || hit;
  assign accept     = mem_req_o && mem_ack_i;
  assign push       = (state == FETCH) && accept && !redirect;

  assign cpu_valid_o = hit;
  assign cpu_inst_o  = hit ? fifo_inst[rd_ptr] : '0;
  assign stallreq_o  = ce && !hit;

  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    case (state)
      IDLE: begin
        if (ce) state_next = FETCH;
      end
      FETCH: begin
        // A fresh request is not issued in a redirect cycle; it would fetch a stale address.
        mem_req_o = pending || (!redirect && space);
        if (redirect) state_next = (pending && !accept) ? DISCARD : FETCH;
      end
      DISCARD: begin
        mem_req_o = 1'b1;
        if (redirect) state_next = (pending && !accept) ? DISCARD : FETCH;
        else if (accept) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    if (mem_req_o) mem_addr_o = pending ? req_addr : fetch_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= '0;
      req_addr   <= '0;
      pending    <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) pending <= 1'b0;
      else if (mem_req_o) pending <= 1'b1;

      // Latch the address when a request is first raised so it stays stable,
      // even if fetch_addr moves on because of a redirect.
      if (mem_req_o && !pending) req_addr <= fetch_addr;

      if (state == IDLE) begin
        if (ce) fetch_addr <= cpu_addr_i;
      end else if (redirect) begin
        fetch_addr <= cpu_addr_i;
      end else if (push) begin
        fetch_addr <= fetch_addr + ADDR_W'(4);
      end

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (hit)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !hit)      count <= count + CNT_W'(1);
        else if (!push && hit) count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= fetch_addr;
      fifo_inst[wr_ptr] <= mem_rdata_i;
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o      <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (redirect && (redirect_cnt_o != 32'hFFFF_FFFF))
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule
